// File: rtl/mem_port_controller_if.sv
// Pipeline-side bundle of the data-memory port controller:
// M-stage request fields plus the stall and load-data return.
interface mem_port_controller_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic        IsByteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] RDM;
    logic        RDValidM;

    modport master (
        output MemReqM, MemWriteM, IsByteM, AddrM, WriteDataM,
        input  StallM, RDM, RDValidM
    );

    modport slave (
        input  MemReqM, MemWriteM, IsByteM, AddrM, WriteDataM,
        output StallM, RDM, RDValidM
    );
endinterface

// File: rtl/mem_port_controller.sv
// Data-memory port sequencer: byte stores via read-modify-write.
// Define MEM_CTRL_LOADER_EN to add the loader port and its arbitration.
module mem_port_controller
`ifdef MEM_CTRL_LOADER_EN
    #(parameter int STARVE_LIMIT = 4)
`endif
(
    input  logic                  CLK,
    input  logic                  RST_N,
    mem_port_controller_if.slave  pif,
`ifdef MEM_CTRL_LOADER_EN
    input  logic                  LdReq,
    input  logic                  LdWrite,
    input  logic [31:0]           LdAddr,
    input  logic [31:0]           LdWData,
    output logic                  LdAck,
    output logic [31:0]           LdRData,
`endif
    output logic [31:0]           MemA,
    output logic [31:0]           MemWD,
    output logic                  MemWE,
    input  logic [31:0]           MemRD
);

`ifdef MEM_CTRL_LOADER_EN
    typedef enum logic [1:0] {S_IDLE, S_RMW_WR, S_LD_ACK} state_t;
`else
    typedef enum logic {S_IDLE, S_RMW_WR} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rmw_word;
    logic [31:0] r_rmw_addr;
    logic        w_rmw_cap;
    logic        w_stall;
    logic [31:0] w_rdm;
    logic [31:0] w_mem_a;
    logic [31:0] w_mem_wd;
    logic        w_mem_we;
    logic [4:0]  w_sh;
    logic [7:0]  w_lane;
    logic [31:0] w_merge;

    assign w_sh    = {pif.AddrM[1:0], 3'b000};
    assign w_lane  = 8'(MemRD >> w_sh);
    assign w_merge = (MemRD & ~(32'h0000_00FF << w_sh))
                   | ({24'h0, pif.WriteDataM[7:0]} << w_sh);

`ifdef MEM_CTRL_LOADER_EN
    logic [3:0]  r_starve_cnt;
    logic [31:0] r_ld_rdata;
    logic        w_ld_grant;
    logic        w_conflict;
    logic        w_unused_ld;

    // Pipeline wins conflicts until it has starved the loader long enough.
    assign w_ld_grant = (r_state == S_IDLE) && LdReq
                      && (!pif.MemReqM || r_starve_cnt == 4'(STARVE_LIMIT));
    assign w_conflict = (r_state == S_IDLE) && LdReq && pif.MemReqM
                      && !w_ld_grant;
    assign w_unused_ld = ^LdAddr[1:0];
    assign LdAck   = RST_N && (r_state == S_LD_ACK);
    assign LdRData = RST_N ? r_ld_rdata : 32'h0;
`endif

    always_comb begin
        w_next    = S_IDLE;
        w_mem_a   = 32'h0;
        w_mem_wd  = 32'h0;
        w_mem_we  = 1'b0;
        w_stall   = 1'b0;
        w_rdm     = 32'h0;
        w_rmw_cap = 1'b0;
        if (r_state == S_RMW_WR) begin
            w_mem_a  = r_rmw_addr;
            w_mem_wd = r_rmw_word;
            w_mem_we = 1'b1;
        end
`ifdef MEM_CTRL_LOADER_EN
        else if (w_ld_grant) begin
            w_mem_a  = {LdAddr[31:2], 2'b00};
            w_mem_wd = LdWData;
            w_mem_we = LdWrite;
            w_stall  = pif.MemReqM;
            w_next   = S_LD_ACK;
        end
`endif
        else if (pif.MemReqM) begin
            w_mem_a = pif.AddrM;
            if (pif.MemWriteM && pif.IsByteM) begin
                w_stall   = 1'b1;
                w_rmw_cap = 1'b1;
                w_next    = S_RMW_WR;
            end else if (pif.MemWriteM) begin
                w_mem_wd = pif.WriteDataM;
                w_mem_we = 1'b1;
            end else if (pif.IsByteM) begin
                w_rdm = {{24{w_lane[7]}}, w_lane};
            end else begin
                w_rdm = MemRD;
            end
        end
        // Nothing may reach the memory or the pipeline while in reset.
        if (!RST_N) begin
            w_mem_a   = 32'h0;
            w_mem_wd  = 32'h0;
            w_mem_we  = 1'b0;
            w_stall   = 1'b0;
            w_rdm     = 32'h0;
            w_rmw_cap = 1'b0;
        end
    end

    assign MemA         = w_mem_a;
    assign MemWD        = w_mem_wd;
    assign MemWE        = w_mem_we;
    assign pif.StallM   = w_stall;
    assign pif.RDM      = w_rdm;
    assign pif.RDValidM = RST_N && pif.MemReqM && !pif.MemWriteM && !w_stall;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_rmw_word <= 32'h0;
            r_rmw_addr <= 32'h0;
`ifdef MEM_CTRL_LOADER_EN
            r_starve_cnt <= 4'h0;
            r_ld_rdata   <= 32'h0;
`endif
        end else begin
            r_state <= w_next;
            if (w_rmw_cap) begin
                r_rmw_word <= w_merge;
                r_rmw_addr <= pif.AddrM;
            end
`ifdef MEM_CTRL_LOADER_EN
            if (w_ld_grant) begin
                r_ld_rdata   <= MemRD;
                r_starve_cnt <= 4'h0;
            end else if (w_conflict && r_starve_cnt != 4'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'h1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_controller.sv
// Scoreboard bench for mem_port_controller against a byte-array memory model.
// Loader scenarios run when MEM_CTRL_LOADER_EN is defined.
module tb_mem_port_controller;
    logic        CLK;
    logic        RST_N;
    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic        MemWE;
    logic [31:0] MemRD;
`ifdef MEM_CTRL_LOADER_EN
    logic        LdReq;
    logic        LdWrite;
    logic [31:0] LdAddr;
    logic [31:0] LdWData;
    logic        LdAck;
    logic [31:0] LdRData;
`endif

    mem_port_controller_if pif();

`ifdef MEM_CTRL_LOADER_EN
    mem_port_controller #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .pif(pif),
        .LdReq(LdReq), .LdWrite(LdWrite), .LdAddr(LdAddr),
        .LdWData(LdWData), .LdAck(LdAck), .LdRData(LdRData),
        .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
    );
`else
    mem_port_controller dut (
        .CLK(CLK), .RST_N(RST_N), .pif(pif),
        .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
    );
`endif

    // Memory instance: combinational read, write on rising edge.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_a;
    logic [31:0] pre_d;
    always @(posedge CLK) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (MemWE) mem[MemA[9:2]] <= MemWD;
    end
    assign MemRD = mem[MemA[9:2]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  ref_b [1024];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b = a & ~3;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    function automatic logic [31:0] ref_load(input int a, input bit byt);
        logic [7:0] v;
        if (!byt) return ref_word(a);
        v = ref_b[a];
        return v[7] ? (32'hFFFF_FF00 | 32'(v)) : 32'(v);
    endfunction

    task automatic ref_store(input int a, input bit byt, input logic [31:0] d);
        if (byt) ref_b[a] = d[7:0];
        else for (int k = 0; k < 4; k++) ref_b[(a & ~3) + k] = 8'(d >> (8 * k));
    endtask

    // Monitor: every valid load data beat pops the next expected value.
    always @(negedge CLK) begin
        if (RST_N && pif.RDValidM) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdm_unexpected got=%h exp=none", pif.RDM);
            end else begin
                chk("rdm", pif.RDM, exp_q.pop_front());
            end
        end
    end

    task automatic pipe_op(input bit w, input bit byt, input int a,
                           input logic [31:0] d);
        int  stalls = 0;
        bit  done = 0;
        pif.MemReqM    = 1'b1;
        pif.MemWriteM  = w;
        pif.IsByteM    = byt;
        pif.AddrM      = 32'(a);
        pif.WriteDataM = d;
        if (w) ref_store(a, byt, d);
        else exp_q.push_back(ref_load(a, byt));
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge CLK);
            if (pif.StallM) stalls++;
            else done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout got=%0d exp=%0d", stalls, w && byt);
        end
        chk("stall_cycles", 32'(stalls), (w && byt) ? 32'd1 : 32'd0);
        @(posedge CLK);
        #1;
        pif.MemReqM = 1'b0;
    endtask

    initial begin
        int a;
        logic [31:0] d;
        RST_N = 1'b0;
        pre_we = 1'b0;
        pre_a = 8'h0;
        pre_d = 32'h0;
        pif.MemReqM = 1'b1;
        pif.MemWriteM = 1'b1;
        pif.IsByteM = 1'b0;
        pif.AddrM = 32'h40;
        pif.WriteDataM = 32'h1234_5678;
`ifdef MEM_CTRL_LOADER_EN
        LdReq = 1'b1;
        LdWrite = 1'b1;
        LdAddr = 32'h80;
        LdWData = 32'h5555_AAAA;
`endif
        // Preload memory while reset keeps the controller silent.
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            pre_we = 1'b1;
            pre_a  = 8'(i);
            pre_d  = $urandom;
            for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'(pre_d >> (8 * k));
            if (i == 3) begin
                chk("rst_memwe", 32'(MemWE), 32'd0);
                chk("rst_stall", 32'(pif.StallM), 32'd0);
                chk("rst_mema", MemA, 32'h0);
                chk("rst_memwd", MemWD, 32'h0);
                chk("rst_rdvalid", 32'(pif.RDValidM), 32'd0);
`ifdef MEM_CTRL_LOADER_EN
                chk("rst_ldack", 32'(LdAck), 32'd0);
                chk("rst_ldrdata", LdRData, 32'h0);
`endif
            end
        end
        @(negedge CLK);
        pre_we = 1'b0;
        pif.MemReqM = 1'b0;
`ifdef MEM_CTRL_LOADER_EN
        LdReq = 1'b0;
`endif
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        pipe_op(1, 0, 'h100, 32'hDEAD_BEEF);
        pipe_op(0, 0, 'h100, 32'h0);
        pipe_op(1, 0, 'h100, 32'h1122_3344);
        pipe_op(1, 1, 'h102, 32'h0000_00AB);
        pipe_op(0, 0, 'h100, 32'h0);
        pipe_op(0, 1, 'h102, 32'h0);
        pipe_op(1, 0, 'h100, 32'h0000_8000);
        pipe_op(0, 1, 'h101, 32'h0);
        pipe_op(0, 1, 'h100, 32'h0);
        pipe_op(1, 1, 'h1F1, 32'h0000_0012);
        pipe_op(1, 1, 'h1F3, 32'h0000_00F0);
        pipe_op(0, 0, 'h1F0, 32'h0);

        // Reset during the write half of a byte store drops the write.
        a = 'h2A5;
        pif.MemReqM = 1'b1;
        pif.MemWriteM = 1'b1;
        pif.IsByteM = 1'b1;
        pif.AddrM = 32'(a);
        pif.WriteDataM = 32'h0000_0077;
        @(negedge CLK);
        chk("rmw_rst_stall", 32'(pif.StallM), 32'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        pif.MemReqM = 1'b0;
        @(negedge CLK);
        chk("rmw_rst_memwe", 32'(MemWE), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        pipe_op(0, 0, a & ~3, 32'h0);

`ifdef MEM_CTRL_LOADER_EN
        // Pipeline and loader both held: loader forced through on cycle 5.
        pif.MemReqM = 1'b1;
        pif.MemWriteM = 1'b0;
        pif.IsByteM = 1'b0;
        pif.AddrM = 32'h0000_0060;
        LdReq = 1'b1;
        LdWrite = 1'b0;
        LdAddr = 32'h0000_0331;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc != 5) exp_q.push_back(ref_word('h60));
            @(negedge CLK);
            chk("starve_stall", 32'(pif.StallM), (cyc == 5) ? 32'd1 : 32'd0);
            chk("starve_ldack", 32'(LdAck), (cyc == 6) ? 32'd1 : 32'd0);
            if (cyc == 5) chk("starve_mema", MemA, 32'h0000_0330);
            if (cyc == 6) chk("ld_rdata", LdRData, ref_word('h330));
            @(posedge CLK);
            #1;
        end
        pif.MemReqM = 1'b0;
        LdReq = 1'b0;

        // Loader write with the pipeline idle.
        @(posedge CLK);
        #1;
        LdReq = 1'b1;
        LdWrite = 1'b1;
        LdAddr = 32'h0000_0203;
        LdWData = 32'hCAFE_F00D;
        @(negedge CLK);
        chk("ldw_memwe", 32'(MemWE), 32'd1);
        chk("ldw_mema", MemA, 32'h0000_0200);
        chk("ldw_memwd", MemWD, 32'hCAFE_F00D);
        chk("ldw_stall", 32'(pif.StallM), 32'd0);
        chk("ldw_ack_early", 32'(LdAck), 32'd0);
        ref_store('h200, 0, 32'hCAFE_F00D);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("ldw_ack", 32'(LdAck), 32'd1);
        chk("ldw_no_regrant", 32'(MemWE), 32'd0);
        @(posedge CLK);
        #1;
        LdReq = 1'b0;
        @(posedge CLK);
        #1;
`endif

        for (int n = 0; n < 300; n++) begin
            bit w = 1'($urandom);
            bit byt = 1'($urandom);
            a = int'($urandom_range(0, 1023));
            if (!byt) a = a & ~3;
            d = $urandom;
            pipe_op(w, byt, a, d);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        @(posedge CLK);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 256; i++) chk("mem_word", mem[i], ref_word(4 * i));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_controller.md
# mem_port_controller

Sequencer and arbiter for the single-ported data memory behind the Memory stage. It turns each pipeline access into one or two memory cycles: word loads/stores and byte loads take one cycle, byte stores take a two-cycle read-modify-write. It also shares the port with a loader/debug requester, using bounded-starvation arbitration, and stalls the pipeline whenever the M-stage access cannot finish this cycle. It sits between the M pipeline register outputs and the `Memory` instance, which has a combinational read and a write on the CLK rising edge.

## Interface
- STARVE_LIMIT, 4: consecutive conflict cycles the pipeline may win before the loader is forced through (1..15).
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous reset, active-low.
- MemReqM  in  1  M stage holds a load or store.
- MemWriteM  in  1  1 = store, 0 = load.
- IsByteM  in  1  byte access; lane = AddrM[1:0].
- AddrM  in  32  byte address.
- WriteDataM  in  32  store data; a byte store uses bits [7:0].
- StallM  out  1  M access not complete this cycle; upstream holds its inputs.
- RDM  out  32  load data; a byte load is sign-extended from the selected lane.
- RDValidM  out  1  RDM valid this cycle.
- LdReq  in  1  loader request; held until LdAck.
- LdWrite  in  1  loader store.
- LdAddr  in  32  word address; bits [1:0] ignored.
- LdWData  in  32  loader store data.
- LdAck  out  1  one-cycle pulse; loader access done.
- LdRData  out  32  registered loader read data, valid with LdAck.
- MemA  out  32  memory address.
- MemWD  out  32  memory write data.
- MemWE  out  1  memory write enable.
- MemRD  in  32  memory read data (combinational).

## Operation
- The FSM has three states: IDLE, RMW_WR and LD_ACK. Reset state is IDLE.
- **IDLE, pipeline owns the port:**
  - Word load: MemA=AddrM, RDM=MemRD, RDValidM=1.
  - Word store: MemWD=WriteDataM, MemWE=1.
  - Byte load: RDM = sign-extended MemRD[8*idx+7:8*idx], where idx=AddrM[1:0].
  - In all three cases StallM=0.
- **IDLE, byte store:**
  - Capture into `rmw_word`: MemRD with lane idx replaced by WriteDataM[7:0].
  - Capture `rmw_addr`=AddrM.
  - MemWE=0, StallM=1, then go to RMW_WR.
- **RMW_WR:** MemA=rmw_addr, MemWD=rmw_word, MemWE=1, StallM=0, then go to IDLE. LdReq is ignored in this state.
- **IDLE, loader granted:**
  - Drive MemA={LdAddr[31:2],2'b00}, MemWD=LdWData, MemWE=LdWrite.
  - Register MemRD into LdRData.
  - StallM=MemReqM, then go to LD_ACK.
- **LD_ACK:** LdAck=1 and the loader is not re-granted. A pipeline access is served exactly as in IDLE; a byte store goes to RMW_WR, otherwise the next state is IDLE.
- **Arbitration in IDLE:**
  - Loader only: the loader is granted.
  - Pipeline only: the pipeline is granted.
  - Both requesting: the pipeline wins and `starve_cnt` increments. When `starve_cnt`==STARVE_LIMIT the loader wins instead.
  - `starve_cnt` clears on every loader grant and saturates at STARVE_LIMIT.
- **Defaults:** RDValidM = MemReqM & ~MemWriteM & ~StallM. Outputs are 0 when not driven.

## Timing
- Every output is 0 while RST_N=0, including MemWE, so no write can occur during reset. State returns to IDLE, `starve_cnt`=0 and LdRData=0.
- Reset asserted mid-RMW (in RMW_WR): the pending write is discarded.
- Reset asserted while in LD_ACK: no LdAck pulse is produced; the loader must re-request.
- Word access or byte load: zero stall cycles; read data is combinational in the same cycle.
- Byte store: exactly 1 stall cycle; the memory write lands on the second rising edge.
- Loader grant: 1 stall cycle for a concurrent M request. LdAck follows the grant by 1 cycle.
- Worst-case loader latency: STARVE_LIMIT+1 cycles to grant (ignoring RMW_WR cycles), then +1 to LdAck.
- Back-to-back byte stores: IDLE, RMW_WR, IDLE, RMW_WR, so two memory cycles each.

## Configuration
- MEM_CTRL_LOADER_EN defined: the loader ports, arbitration, `starve_cnt` and LD_ACK are present as specified above.
- Undefined:
  - The Ld* ports do not exist, STARVE_LIMIT is unused and the FSM has IDLE and RMW_WR only.
  - StallM is asserted only in the first cycle of a byte store.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load 0x100 -> RDM=0xDEADBEEF, RDValidM=1, StallM=0 throughout.
- Preload 0x11223344 at 0x100; byte store 0xAB to 0x102 -> StallM high for 1 cycle, memory=0x11AB3344; byte load 0x102 -> RDM=0xFFFFFFAB.
- Byte load 0x101 of 0x00008000 -> RDM=0xFFFFFF80; 0x100 -> 0x00000000.
- MEM_CTRL_LOADER_EN with STARVE_LIMIT=4, MemReqM and LdReq held high continuously:
  - The loader is granted on cycle 5, StallM=1 that cycle, and LdAck follows on cycle 6.
  - LdRData equals the word at LdAddr.
- Byte store started, RST_N low in the RMW_WR cycle -> MemWE stays 0, memory unchanged, FSM back in IDLE.
- Loader write 0xCAFEF00D to 0x203 with the pipeline idle -> written at 0x200, LdAck 1 cycle later, StallM=0.
